// File: rtl/spi_slave_byte.sv
// spi_slave_byte: SPI mode-0 slave oversampled in the clk domain; MSB-first byte rx/tx.
// Define SPI_SLAVE_RX_FIFO_EN to buffer received bytes in an RX_DEPTH-entry FIFO with overrun flag.
module spi_slave_byte #(
  parameter logic [7:0] TX_IDLE  = 8'hFF,
  parameter int         RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       nss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       frame_abort
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e     state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] nss_sync_q, nss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;
  logic       tx_ready_q, tx_ready_d;
  logic       frame_abort_q, frame_abort_d;

  logic       sclk_rise, sclk_fall, nss_rise, nss_fall, mosi_s;
  logic       byte_done;
  logic [7:0] byte_val, load_byte;

  // nss synchroniser resets low so a select already held low at reset release is not seen as a fall
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    nss_sync_d  = {nss_sync_q[1:0], nss};
    mosi_sync_d = {mosi_sync_q[0], mosi};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign nss_rise  = nss_sync_q[1] & ~nss_sync_q[2];
  assign nss_fall  = ~nss_sync_q[1] & nss_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  assign byte_val  = {rx_shift_q, mosi_s};
  assign load_byte = tx_valid ? tx_data : TX_IDLE;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    tx_ready_d    = 1'b0;
    frame_abort_d = 1'b0;
    byte_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (nss_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = 3'd0;
          tx_shift_d = load_byte;
          miso_d     = load_byte[7];
          miso_oe_d  = 1'b1;
          tx_ready_d = tx_valid;
        end
      end
      ACTIVE: begin
        // Deselect takes priority over any sclk edge seen in the same cycle
        if (nss_rise) begin
          state_d       = IDLE;
          bit_cnt_d     = 3'd0;
          miso_d        = 1'b0;
          miso_oe_d     = 1'b0;
          frame_abort_d = (bit_cnt_q != 3'd0);
        end else if (sclk_rise) begin
          rx_shift_d = byte_val[6:0];
          bit_cnt_d  = bit_cnt_q + 3'd1;
          byte_done  = (bit_cnt_q == 3'd7);
        end else if (sclk_fall) begin
          if (bit_cnt_q == 3'd0) begin
            tx_shift_d = load_byte;
            miso_d     = load_byte[7];
            tx_ready_d = tx_valid;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], tx_shift_q[7]};
            miso_d     = tx_shift_q[6];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sclk_sync_q   <= 3'b000;
      nss_sync_q    <= 3'b000;
      mosi_sync_q   <= 2'b00;
      bit_cnt_q     <= 3'd0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      tx_ready_q    <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      nss_sync_q    <= nss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      tx_ready_q    <= tx_ready_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // Shift registers are fully reloaded before use, so they carry no reset
  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign frame_abort = frame_abort_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(RX_DEPTH);

  logic [7:0]  fifo_mem_q [RX_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overrun_q, overrun_d;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop   = !fifo_empty && rx_ready;
  // A pop in the same cycle frees the slot a commit into a full FIFO needs
  assign fifo_push  = byte_done && (!fifo_full || fifo_pop);

  always_comb begin
    wr_ptr_d  = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overrun_d = overrun_q | (byte_done && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= byte_val;
  end

  assign rx_valid   = !fifo_empty;
  assign rx_data    = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign rx_overrun = overrun_q;
`else
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       unused_rx;

  always_comb begin
    rx_data_d  = byte_done ? byte_val : rx_data_q;
    rx_valid_d = byte_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Without the FIFO there is no backpressure, so the consumer handshake is not used
  assign unused_rx  = ^{rx_ready, RX_DEPTH};
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: SPI mode-0 master model with rx/miso scoreboards.
`timescale 1ns/1ps
module tb_spi_slave_byte;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       nss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_overrun, frame_abort;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_pass = 0;
  int tx_ready_cnt = 0;
  int abort_cnt = 0;
  int rx_cnt = 0;
  int rx_extra = 0;

  logic [7:0] rx_exp_q[$];
  logic [7:0] miso_exp_q[$];
  logic [7:0] tx_feed_q[$];

  always #5 clk = ~clk;

  spi_slave_byte #(.TX_IDLE(8'hFF), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .nss(nss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .frame_abort(frame_abort)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Firmware-side model: feeds the next tx byte on each tx_ready, pops rx bytes into the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_ready) begin
        tx_ready_cnt++;
        if (tx_feed_q.size() > 0) tx_data = tx_feed_q.pop_front();
        else tx_valid = 1'b0;
      end
      if (frame_abort) abort_cnt++;
      if (rx_valid && rx_ready) begin
        rx_cnt++;
        if (rx_exp_q.size() > 0) check_eq("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
        else rx_extra++;
      end
    end
  end

  task automatic frame_start();
    nss = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    nss = 1'b1;
    #(4*HALF);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      #HALF;
      mi[7-i] = miso;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] mo, input logic [7:0] exp_miso, input bit exp_rx);
    logic [7:0] mi;
    if (exp_rx) rx_exp_q.push_back(mo);
    miso_exp_q.push_back(exp_miso);
    spi_bits(mo, 8, mi);
    check_eq("miso_byte", {24'd0, mi}, {24'd0, miso_exp_q.pop_front()});
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && rx_exp_q.size() != 0; i++) @(negedge clk);
    check_eq({tag, "_drain"}, rx_exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a0, r0;
    logic [7:0] mi;

    repeat (3) @(negedge clk);
    check_eq("rst_miso", miso, 0);
    check_eq("rst_miso_oe", miso_oe, 0);
    check_eq("rst_tx_ready", tx_ready, 0);
    check_eq("rst_rx_data", {24'd0, rx_data}, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_overrun", rx_overrun, 0);
    check_eq("rst_frame_abort", frame_abort, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single byte with a pending tx byte
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    c0 = tx_ready_cnt;
    frame_start();
    check_eq("t1_oe_active", miso_oe, 1);
    send_byte(8'hA5, 8'h3C, 1'b1);
    frame_end();
    wait_drain("t1");
    check_eq("t1_tx_ready_pulses", tx_ready_cnt - c0, 1);
    check_eq("t1_oe_idle", miso_oe, 0);
    check_eq("t1_miso_idle", miso, 0);
    check_eq("t1_no_abort", abort_cnt, 0);

    // three bytes, nothing to transmit
    c0 = tx_ready_cnt;
    frame_start();
    send_byte(8'h01, 8'hFF, 1'b1);
    send_byte(8'h02, 8'hFF, 1'b1);
    send_byte(8'h03, 8'hFF, 1'b1);
    frame_end();
    wait_drain("t2");
    check_eq("t2_tx_ready_pulses", tx_ready_cnt - c0, 0);
    check_eq("t2_no_abort", abort_cnt, 0);

    // aborted frame after 5 bits, then a clean byte
    a0 = abort_cnt;
    r0 = rx_cnt;
    frame_start();
    spi_bits(8'hF0, 5, mi);
    frame_end();
    check_eq("t3_abort_pulses", abort_cnt - a0, 1);
    check_eq("t3_no_rx", rx_cnt - r0, 0);
    frame_start();
    send_byte(8'h7E, 8'hFF, 1'b1);
    frame_end();
    wait_drain("t3");
    check_eq("t3_abort_after_full", abort_cnt - a0, 1);

`ifdef SPI_SLAVE_RX_FIFO_EN
    // overflow the FIFO while the consumer stalls
    rx_ready = 1'b0;
    frame_start();
    for (int b = 0; b < 5; b++) send_byte(8'h10 + 8'(b), 8'hFF, (b < 4));
    frame_end();
    check_eq("t4_overrun", rx_overrun, 1);
    check_eq("t4_valid_held", rx_valid, 1);
    check_eq("t4_head", {24'd0, rx_data}, 32'h10);
    rx_ready = 1'b1;
    wait_drain("t4");
    repeat (4) @(negedge clk);
    check_eq("t4_empty", rx_valid, 0);
    check_eq("t4_overrun_sticky", rx_overrun, 1);
`endif

    // reset in the middle of a byte
    a0 = abort_cnt;
    frame_start();
    spi_bits(8'h5A, 4, mi);
    rst = 1'b1;
    #10;
    check_eq("t5_rst_miso", miso, 0);
    check_eq("t5_rst_miso_oe", miso_oe, 0);
    check_eq("t5_rst_tx_ready", tx_ready, 0);
    check_eq("t5_rst_rx_data", {24'd0, rx_data}, 0);
    check_eq("t5_rst_rx_valid", rx_valid, 0);
    check_eq("t5_rst_rx_overrun", rx_overrun, 0);
    check_eq("t5_rst_frame_abort", frame_abort, 0);
    rst = 1'b0;
    spi_bits(8'hFF, 4, mi);
    check_eq("t5_no_resume_oe", miso_oe, 0);
    frame_end();
    check_eq("t5_no_abort", abort_cnt - a0, 0);
    frame_start();
    send_byte(8'hC3, 8'hFF, 1'b1);
    frame_end();
    wait_drain("t5");

    // tx stream via handshake
    tx_data = 8'h11;
    tx_valid = 1'b1;
    tx_feed_q.push_back(8'h22);
    tx_feed_q.push_back(8'h33);
    c0 = tx_ready_cnt;
    frame_start();
    send_byte(8'hA1, 8'h11, 1'b1);
    send_byte(8'hA2, 8'h22, 1'b1);
    send_byte(8'hA3, 8'h33, 1'b1);
    frame_end();
    wait_drain("t6");
    check_eq("t6_tx_ready_pulses", tx_ready_cnt - c0, 3);

    repeat (10) @(negedge clk);
    check_eq("no_unexpected_rx", rx_extra, 0);
`ifndef SPI_SLAVE_RX_FIFO_EN
    check_eq("no_overrun", rx_overrun, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
